// File: rtl/key_onehot_capture.sv
// -----------------------------------------------------------------------------
// key_onehot_capture
//   Front end for the 4-to-2 encoder stage. Four raw, bouncy, active-high
//   push buttons are each synchronized (2 flops) and debounced. Every debounced
//   press (rising edge of the stable value) loads a single held one-hot code
//   that drives the encoder's a/b/c/d inputs. This means the encoder never sees
//   more than one active input at a time.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive synchronized cycles an input must differ from
//                     its stable value before the stable value flips (2..65535)
//   CNT_W           : debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   key_in     in   [3:0] raw buttons, bit0=a .. bit3=d
//   clr        in   synchronous clear of the held code (a press wins over it)
//   onehot_out out  [3:0] held one-hot code, 0000 = nothing held
//   valid      out  high while onehot_out is non-zero
//   press_stb  out  one-cycle pulse on the edge onehot_out is loaded
//   multi_err  out  (only with KEY_ONEHOT_MULTI_ERR_EN) one-cycle pulse
//                   alongside press_stb when two or more presses coincide
//
// Optional feature macro: KEY_ONEHOT_MULTI_ERR_EN
// -----------------------------------------------------------------------------
module key_onehot_capture #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_in,
    input  logic       clr,
    output logic [3:0] onehot_out,
    output logic       valid,
    output logic       press_stb
`ifdef KEY_ONEHOT_MULTI_ERR_EN
    ,
    output logic       multi_err
`endif
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync1_r;
    logic [3:0]       sync2_r;
    logic [3:0]       q_r;
    logic [3:0]       q_d_r;
    logic [CNT_W-1:0] cnt_r [4];
    logic [3:0]       press_s;
    state_t           state_r;
    state_t           state_s;
    logic [3:0]       code_s;
    logic             stb_s;

    // Highest-index key wins when several presses land in the same cycle.
    function automatic logic [3:0] pick_highest(input logic [3:0] ev);
        logic [3:0] r;
        if (ev[3]) begin
            r = 4'b1000;
        end else if (ev[2]) begin
            r = 4'b0100;
        end else if (ev[1]) begin
            r = 4'b0010;
        end else if (ev[0]) begin
            r = 4'b0001;
        end else begin
            r = 4'b0000;
        end
        return r;
    endfunction

    // Two-flop synchronizer for the asynchronous button inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
        end else begin
            sync1_r <= key_in;
            sync2_r <= sync1_r;
        end
    end

    // Per-bit debounce: the stable value flips only after DEBOUNCE_CYCLES
    // consecutive mismatching samples; any match restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] == q_r[i]) begin
                    cnt_r[i] <= CNT_ZERO;
                end else if (cnt_r[i] == CNT_LAST) begin
                    q_r[i]   <= sync2_r[i];
                    cnt_r[i] <= CNT_ZERO;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Delayed copy of the stable values for rising-edge (press) detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_d_r <= 4'b0000;
        end else begin
            q_d_r <= q_r;
        end
    end

    // Only rising edges count; releases are ignored.
    assign press_s = q_r & ~q_d_r;

    // Capture FSM next state and next output values; a press beats clr.
    always_comb begin
        state_s = state_r;
        code_s  = onehot_out;
        stb_s   = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (press_s != 4'b0000) begin
                    state_s = ST_HELD;
                    code_s  = pick_highest(press_s);
                    stb_s   = 1'b1;
                end else begin
                    state_s = ST_EMPTY;
                    code_s  = 4'b0000;
                end
            end
            ST_HELD: begin
                if (press_s != 4'b0000) begin
                    state_s = ST_HELD;
                    code_s  = pick_highest(press_s);
                    stb_s   = 1'b1;
                end else if (clr) begin
                    state_s = ST_EMPTY;
                    code_s  = 4'b0000;
                end else begin
                    state_s = ST_HELD;
                end
            end
            default: begin
                state_s = ST_EMPTY;
                code_s  = 4'b0000;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_EMPTY;
            onehot_out <= 4'b0000;
            valid      <= 1'b0;
            press_stb  <= 1'b0;
        end else begin
            state_r    <= state_s;
            onehot_out <= code_s;
            valid      <= (state_s == ST_HELD);
            press_stb  <= stb_s;
        end
    end

`ifdef KEY_ONEHOT_MULTI_ERR_EN
    logic multi_s;

    // Two or more simultaneous presses: clearing the lowest set bit leaves
    // something behind.
    assign multi_s = (press_s & (press_s - 4'b0001)) != 4'b0000;

    // Registered coincidence flag, aligned with press_stb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multi_err <= 1'b0;
        end else begin
            multi_err <= multi_s;
        end
    end
`endif

endmodule

// File: doc/key_onehot_capture.md
Name: key_onehot_capture

Overview:
- Upstream front end for the 4-to-2 encoder stage.
- Takes four raw, bouncy push-button inputs and synchronizes and debounces each one.
- Converts each debounced press into a single held one-hot code, which drives the encoder's a/b/c/d inputs.
- Guarantees the encoder never sees more than one active input, so its c|d and b|d outputs are always a valid index.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized clock cycles an input must differ from its stable value before the stable value flips; legal range 2..65535.
CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock; all flops rising-edge.
rst_n  input  1  asynchronous active-low reset.
key_in  input  4  raw asynchronous buttons, active-high; bit0=a, bit1=b, bit2=c, bit3=d.
clr  input  1  synchronous clear of the held code.
onehot_out  output  4  held one-hot code to the encoder (bit0..3 -> a..d); all-zero means nothing held.
valid  output  1  high while onehot_out is non-zero.
press_stb  output  1  one-cycle pulse, asserted on the same edge onehot_out is loaded.

Behaviour:
- Reset:
  - rst_n low asynchronously clears the sync flops, stable values, counters, onehot_out, valid and press_stb.
  - Release is synchronous to clk; the first press can register no earlier than DEBOUNCE_CYCLES+3 edges after release.
- Synchronizer: each key_in bit passes through a 2-flop synchronizer (sync1, sync2).
- Debounce, per bit:
  - Registers: stable value q, counter cnt.
  - sync2==q: cnt<=0.
  - sync2!=q and cnt==DEBOUNCE_CYCLES-1: q<=sync2, cnt<=0.
  - Otherwise: cnt<=cnt+1.
  - Any bounce back to q before the threshold restarts the count from 0.
- Press event: a rising edge of q (q was 0, now 1), detected against a registered copy of q.
- Latency: if edge 0 is the first clk edge at which key_in bit is high and it stays high:
  - q rises at edge DEBOUNCE_CYCLES+1.
  - press_stb and onehot_out update at edge DEBOUNCE_CYCLES+2.
  - Release (falling q) produces no event.
- Capture state machine, two states:
  - EMPTY (onehot_out=0, valid=0) and HELD (onehot_out one-hot, valid=1).
  - EMPTY -> HELD on a press event.
  - HELD -> HELD on a new press event, with onehot_out replaced by the new key.
  - HELD -> EMPTY on clr with no press event.
  - EMPTY with clr: stays EMPTY.
- Simultaneous press events in one cycle: the highest index wins (d > c > b > a). Exactly one bit is loaded, and press_stb pulses once.
- Press event and clr in the same cycle: the press wins; onehot_out is loaded and valid stays 1.
- press_stb is high for exactly one cycle per loaded press and is never high while rst_n is low.
- Holding a key down produces no repeat. The key must be released (q falls) and pressed again to produce another event.
- Invariant: onehot_out is always 0000 or has exactly one bit set; valid == |onehot_out.
- Mid-operation reset: debounce progress and the held code are lost. A key held through reset re-registers as a press after release, because q restarts at 0.

Optional Feature:
KEY_ONEHOT_MULTI_ERR_EN
- Defined:
  - Adds output multi_err (1 bit, reset 0).
  - multi_err pulses for one cycle, on the same edge as press_stb, whenever two or more press events coincide.
  - The priority resolution is unchanged.
- Undefined:
  - No port and no logic.
  - Simultaneous presses are resolved silently by priority.

Test Plan:
- Reset then idle, DEBOUNCE_CYCLES=4 -> onehot_out=0000, valid=0, press_stb=0 for 20 cycles.
- key_in=0100 first sampled at edge 0 and held -> at edge 6, press_stb=1 for one cycle, onehot_out=0100, valid=1; encoder sees c only.
- key_in bit1 toggles 1,0,1 at 2-cycle spacing, then held -> no strobe until 6 edges after the last rise; then onehot_out=0010.
- Bits 0 and 3 rise on the same edge -> a single strobe, onehot_out=1000; with KEY_ONEHOT_MULTI_ERR_EN, multi_err=1 on that edge.
- While HELD with 0001, assert clr on the same edge as a debounced press of bit2 -> onehot_out=0100, valid stays 1. Then clr alone -> 0000, valid=0.
- Key held, rst_n pulsed low mid-debounce for 1 cycle -> all outputs 0 immediately (asynchronously). Held key gives press_stb 6 edges after the first post-reset sample.
